// File: rtl/complex_issue_pkg.sv
// complex_issue_pkg: shared types and helpers for the mul/div issue queue.
// Source wakeup snooping is shared by the dispatch path and stored entries.
package complex_issue_pkg;

    localparam int CI_TAG_W   = 6;
    localparam int CI_ROB_W   = 5;
    localparam int OP_DIV_BIT = 2;
    localparam int OP_REM_BIT = 1;
    localparam int OP_UNS_BIT = 0;

    typedef struct packed {
        logic [CI_TAG_W-1:0] tag;
        logic [31:0]         data;
        logic                rdy;
    } src_t;

    typedef struct packed {
        logic                valid;
        logic [2:0]          opcode;
        src_t                rs1;
        src_t                rs2;
        logic [CI_TAG_W-1:0] rd_tag;
        logic [CI_ROB_W-1:0] rob_id;
    } iq_entry_t;

    // wk0 wins when both buses carry the awaited tag
    function automatic src_t snoop(
        input src_t                s,
        input logic                v0,
        input logic [CI_TAG_W-1:0] t0,
        input logic [31:0]         d0,
        input logic                v1,
        input logic [CI_TAG_W-1:0] t1,
        input logic [31:0]         d1
    );
        src_t r;
        r = s;
        if (!s.rdy) begin
            if (v0 && t0 == s.tag) begin
                r.data = d0;
                r.rdy  = 1'b1;
            end else if (v1 && t1 == s.tag) begin
                r.data = d1;
                r.rdy  = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/complex_iq_entry.sv
// complex_iq_entry: one issue-queue slot with two-bus wakeup capture.
// Writes pass through the same snoop so dispatch-cycle wakeups are caught.
module complex_iq_entry
    import complex_issue_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                wr_i,
    input  logic                pop_i,
    input  iq_entry_t           wr_entry_i,
    input  logic                wk0_valid_i,
    input  logic [CI_TAG_W-1:0] wk0_tag_i,
    input  logic [31:0]         wk0_data_i,
    input  logic                wk1_valid_i,
    input  logic [CI_TAG_W-1:0] wk1_tag_i,
    input  logic [31:0]         wk1_data_i,
    output logic                ready_o,
    output logic [2:0]          opcode_o,
    output logic [31:0]         op1_o,
    output logic [31:0]         op2_o,
    output logic [CI_TAG_W-1:0] rd_tag_o,
    output logic [CI_ROB_W-1:0] rob_id_o
);

    iq_entry_t ent_q, ent_d, base;

    always_comb begin
        base      = wr_i ? wr_entry_i : ent_q;
        ent_d     = base;
        ent_d.rs1 = snoop(base.rs1, wk0_valid_i, wk0_tag_i, wk0_data_i,
                          wk1_valid_i, wk1_tag_i, wk1_data_i);
        ent_d.rs2 = snoop(base.rs2, wk0_valid_i, wk0_tag_i, wk0_data_i,
                          wk1_valid_i, wk1_tag_i, wk1_data_i);
        if (pop_i || clr_i) begin
            ent_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign ready_o  = ent_q.valid & ent_q.rs1.rdy & ent_q.rs2.rdy;
    assign opcode_o = ent_q.opcode;
    assign op1_o    = ent_q.rs1.data;
    assign op2_o    = ent_q.rs2.data;
    assign rd_tag_o = ent_q.rd_tag;
    assign rob_id_o = ent_q.rob_id;

endmodule

// File: rtl/complex_issue.sv
// complex_issue: in-order issue queue feeding the multiply/divide unit.
// One op in flight; operands stay on the unit bus until its result returns.
module complex_issue
    import complex_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = CI_TAG_W,
    parameter int ROB_W = CI_ROB_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [2:0]       disp_opcode_i,
    input  logic [31:0]      disp_rs1_data_i,
    input  logic [31:0]      disp_rs2_data_i,
    input  logic [TAG_W-1:0] disp_rs1_tag_i,
    input  logic [TAG_W-1:0] disp_rs2_tag_i,
    input  logic             disp_rs1_rdy_i,
    input  logic             disp_rs2_rdy_i,
    input  logic [TAG_W-1:0] disp_rd_tag_i,
    input  logic [ROB_W-1:0] disp_rob_id_i,
    input  logic             wk0_valid_i,
    input  logic [TAG_W-1:0] wk0_tag_i,
    input  logic [31:0]      wk0_data_i,
    input  logic             wk1_valid_i,
    input  logic [TAG_W-1:0] wk1_tag_i,
    input  logic [31:0]      wk1_data_i,
    output logic             cu_flush_o,
    output logic             cu_valid_o,
    output logic [2:0]       cu_opcode_o,
    output logic [31:0]      cu_op1_o,
    output logic [31:0]      cu_op2_o,
    input  logic [31:0]      cu_result_i,
    input  logic             cu_wb_valid_i,
    output logic             wb_valid_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic [ROB_W-1:0] wb_rob_id_o,
    output logic [31:0]      wb_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             inf_q, inf_d;
    logic [TAG_W-1:0] inf_tag_q, inf_tag_d;
    logic [ROB_W-1:0] inf_rob_q, inf_rob_d;
    logic             cuv_q, cuv_d;
    logic [2:0]       cuop_q, cuop_d;
    logic [31:0]      cua_q, cua_d, cub_q, cub_d;
    logic             wbv_q, wbv_d;
    logic [TAG_W-1:0] wbt_q, wbt_d;
    logic [ROB_W-1:0] wbr_q, wbr_d;
    logic [31:0]      wbd_q, wbd_d;

    iq_entry_t        disp_ent;
    logic [DEPTH-1:0] e_rdy;
    logic [2:0]       e_op  [DEPTH];
    logic [31:0]      e_a   [DEPTH];
    logic [31:0]      e_b   [DEPTH];
    logic [TAG_W-1:0] e_tag [DEPTH];
    logic [ROB_W-1:0] e_rob [DEPTH];
    logic             disp_fire, issue, done, unit_free;

    assign cu_flush_o   = flush_i;
    assign disp_ready_o = cnt_q < FULL;
    assign disp_fire    = disp_valid_i & disp_ready_o & ~flush_i;
    // the unit is idle after its done cycle, so back-to-back issue is safe
    assign unit_free    = ~inf_q | cu_wb_valid_i;
    assign issue        = e_rdy[head_q] & unit_free & ~flush_i;
    assign done         = cu_wb_valid_i & inf_q & ~flush_i;

    always_comb begin
        disp_ent          = '0;
        disp_ent.valid    = 1'b1;
        disp_ent.opcode   = disp_opcode_i;
        disp_ent.rs1.tag  = disp_rs1_tag_i;
        disp_ent.rs1.data = disp_rs1_data_i;
        disp_ent.rs1.rdy  = disp_rs1_rdy_i;
        disp_ent.rs2.tag  = disp_rs2_tag_i;
        disp_ent.rs2.data = disp_rs2_data_i;
        disp_ent.rs2.rdy  = disp_rs2_rdy_i;
        disp_ent.rd_tag   = disp_rd_tag_i;
        disp_ent.rob_id   = disp_rob_id_i;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        complex_iq_entry u_ent (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .clr_i       (flush_i),
            .wr_i        (disp_fire && tail_q == AW'(i)),
            .pop_i       (issue && head_q == AW'(i)),
            .wr_entry_i  (disp_ent),
            .wk0_valid_i (wk0_valid_i),
            .wk0_tag_i   (wk0_tag_i),
            .wk0_data_i  (wk0_data_i),
            .wk1_valid_i (wk1_valid_i),
            .wk1_tag_i   (wk1_tag_i),
            .wk1_data_i  (wk1_data_i),
            .ready_o     (e_rdy[i]),
            .opcode_o    (e_op[i]),
            .op1_o       (e_a[i]),
            .op2_o       (e_b[i]),
            .rd_tag_o    (e_tag[i]),
            .rob_id_o    (e_rob[i])
        );
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;
        inf_d     = inf_q;
        inf_tag_d = inf_tag_q;
        inf_rob_d = inf_rob_q;
        cuv_d     = 1'b0;
        cuop_d    = cuop_q;
        cua_d     = cua_q;
        cub_d     = cub_q;
        wbv_d     = 1'b0;
        wbt_d     = wbt_q;
        wbr_d     = wbr_q;
        wbd_d     = wbd_q;
        if (disp_fire) begin
            tail_d = tail_q + 1'b1;
        end
        unique case ({disp_fire, issue})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (done) begin
            wbv_d = 1'b1;
            wbt_d = inf_tag_q;
            wbr_d = inf_rob_q;
            wbd_d = cu_result_i;
            inf_d = 1'b0;
        end
        if (issue) begin
            head_d    = head_q + 1'b1;
            cuv_d     = 1'b1;
            cuop_d    = e_op[head_q];
            cua_d     = e_a[head_q];
            cub_d     = e_b[head_q];
            inf_tag_d = e_tag[head_q];
            inf_rob_d = e_rob[head_q];
            inf_d     = 1'b1;
        end
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            inf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            inf_q     <= 1'b0;
            inf_tag_q <= '0;
            inf_rob_q <= '0;
            cuv_q     <= 1'b0;
            cuop_q    <= '0;
            cua_q     <= '0;
            cub_q     <= '0;
            wbv_q     <= 1'b0;
            wbt_q     <= '0;
            wbr_q     <= '0;
            wbd_q     <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            inf_q     <= inf_d;
            inf_tag_q <= inf_tag_d;
            inf_rob_q <= inf_rob_d;
            cuv_q     <= cuv_d;
            cuop_q    <= cuop_d;
            cua_q     <= cua_d;
            cub_q     <= cub_d;
            wbv_q     <= wbv_d;
            wbt_q     <= wbt_d;
            wbr_q     <= wbr_d;
            wbd_q     <= wbd_d;
        end
    end

    assign cu_valid_o  = cuv_q;
    assign cu_opcode_o = cuop_q;
    assign cu_op1_o    = cua_q;
    assign cu_op2_o    = cub_q;
    assign wb_valid_o  = wbv_q;
    assign wb_tag_o    = wbt_q;
    assign wb_rob_id_o = wbr_q;
    assign wb_data_o   = wbd_q;

    a_orphan_done: assert property (@(posedge clk_i) disable iff (rst_i)
        !(cu_wb_valid_i && !inf_q));

endmodule

// File: tb/tb_complex_issue.sv
// tb_complex_issue: scoreboard bench with a behavioural mul/div unit model.
// Expected issue operands and writeback results are queued at dispatch.
module tb_complex_issue;
    import complex_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        disp_valid_i = 1'b0;
    logic        disp_ready_o;
    logic [2:0]  disp_opcode_i = '0;
    logic [31:0] disp_rs1_data_i = '0, disp_rs2_data_i = '0;
    logic [5:0]  disp_rs1_tag_i = '0, disp_rs2_tag_i = '0;
    logic        disp_rs1_rdy_i = 1'b0, disp_rs2_rdy_i = 1'b0;
    logic [5:0]  disp_rd_tag_i = '0;
    logic [4:0]  disp_rob_id_i = '0;
    logic        wk0_valid_i = 1'b0, wk1_valid_i = 1'b0;
    logic [5:0]  wk0_tag_i = '0, wk1_tag_i = '0;
    logic [31:0] wk0_data_i = '0, wk1_data_i = '0;
    logic        cu_flush_o, cu_valid_o;
    logic [2:0]  cu_opcode_o;
    logic [31:0] cu_op1_o, cu_op2_o;
    logic [31:0] cu_result_i = '0;
    logic        cu_wb_valid_i = 1'b0;
    logic        wb_valid_o;
    logic [5:0]  wb_tag_o;
    logic [4:0]  wb_rob_id_o;
    logic [31:0] wb_data_o;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } iss_t;

    typedef struct packed {
        logic [5:0]  tag;
        logic [4:0]  rob;
        logic [31:0] data;
    } wb_t;

    iss_t iss_q[$];
    wb_t  wb_q[$];
    int   nchk = 0;
    int   nerr = 0;
    int   ulat = 2;
    int   ucnt = 0;
    logic force_done = 1'b0;
    logic [2:0]  h_op;
    logic [31:0] h_a, h_b;

    complex_issue dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_opcode_i   (disp_opcode_i),
        .disp_rs1_data_i (disp_rs1_data_i),
        .disp_rs2_data_i (disp_rs2_data_i),
        .disp_rs1_tag_i  (disp_rs1_tag_i),
        .disp_rs2_tag_i  (disp_rs2_tag_i),
        .disp_rs1_rdy_i  (disp_rs1_rdy_i),
        .disp_rs2_rdy_i  (disp_rs2_rdy_i),
        .disp_rd_tag_i   (disp_rd_tag_i),
        .disp_rob_id_i   (disp_rob_id_i),
        .wk0_valid_i     (wk0_valid_i),
        .wk0_tag_i       (wk0_tag_i),
        .wk0_data_i      (wk0_data_i),
        .wk1_valid_i     (wk1_valid_i),
        .wk1_tag_i       (wk1_tag_i),
        .wk1_data_i      (wk1_data_i),
        .cu_flush_o      (cu_flush_o),
        .cu_valid_o      (cu_valid_o),
        .cu_opcode_o     (cu_opcode_o),
        .cu_op1_o        (cu_op1_o),
        .cu_op2_o        (cu_op2_o),
        .cu_result_i     (cu_result_i),
        .cu_wb_valid_i   (cu_wb_valid_i),
        .wb_valid_o      (wb_valid_o),
        .wb_tag_o        (wb_tag_o),
        .wb_rob_id_o     (wb_rob_id_o),
        .wb_data_o       (wb_data_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] calc(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        logic [31:0] q, r;
        if (!op[OP_DIV_BIT]) return a * b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op[OP_UNS_BIT]) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return op[OP_REM_BIT] ? r : q;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [2:0] op,
                            input logic [31:0] a, input logic ar,
                            input logic [5:0] at,
                            input logic [31:0] b, input logic br,
                            input logic [5:0] bt,
                            input logic [5:0] rd, input logic [4:0] rob,
                            output logic acc);
        wb_t w;
        disp_valid_i    = 1'b1;
        disp_opcode_i   = op;
        disp_rs1_data_i = ar ? a : ~a;
        disp_rs1_rdy_i  = ar;
        disp_rs1_tag_i  = at;
        disp_rs2_data_i = br ? b : ~b;
        disp_rs2_rdy_i  = br;
        disp_rs2_tag_i  = bt;
        disp_rd_tag_i   = rd;
        disp_rob_id_i   = rob;
        acc = disp_ready_o && !flush_i;
        if (acc) begin
            iss_q.push_back({op, a, b});
            w.tag  = rd;
            w.rob  = rob;
            w.data = calc(op, a, b);
            wb_q.push_back(w);
        end
        tick();
        disp_valid_i = 1'b0;
    endtask

    task automatic disp_retry(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [5:0] rd,
                              input logic [4:0] rob);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            dispatch(op, a, 1'b1, 6'd0, b, 1'b1, 6'd0, rd, rob, acc);
        end
        chk("disp_accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (iss_q.size() == 0 && wb_q.size() == 0) break;
            tick();
        end
        chk("drain_left", 64'(iss_q.size() + wb_q.size()), 64'd0);
    endtask

    // unit model and scoreboard; sampled mid-cycle away from the edge
    always @(negedge clk) begin
        iss_t e;
        wb_t  w;
        if (rst) begin
            ucnt          = 0;
            cu_wb_valid_i = 1'b0;
            cu_result_i   = '0;
        end else begin
            cu_wb_valid_i = 1'b0;
            if (cu_valid_o) begin
                if (iss_q.size() == 0) begin
                    chk("iss_unexpected", 64'd1, 64'd0);
                end else begin
                    e = iss_q.pop_front();
                    chk("iss_op", 64'(cu_opcode_o), 64'(e.op));
                    chk("iss_a", 64'(cu_op1_o), 64'(e.a));
                    chk("iss_b", 64'(cu_op2_o), 64'(e.b));
                end
                h_op = cu_opcode_o;
                h_a  = cu_op1_o;
                h_b  = cu_op2_o;
                ucnt = ulat;
            end else if (ucnt > 0) begin
                chk("hold_opa", {29'd0, cu_opcode_o, cu_op1_o},
                    {29'd0, h_op, h_a});
                chk("hold_b", 64'(cu_op2_o), 64'(h_b));
                ucnt--;
                if (ucnt == 0) begin
                    cu_wb_valid_i = 1'b1;
                    cu_result_i   = calc(cu_opcode_o, cu_op1_o, cu_op2_o);
                end
            end
            if (force_done) begin
                cu_wb_valid_i = 1'b1;
                cu_result_i   = 32'h1234_5678;
            end
            if (cu_flush_o) ucnt = 0;
            if (wb_valid_o) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_tag", 64'(wb_tag_o), 64'(w.tag));
                    chk("wb_rob", 64'(wb_rob_id_o), 64'(w.rob));
                    chk("wb_data", 64'(wb_data_o), 64'(w.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cu_valid", 64'(cu_valid_o), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_cu_op", 64'(cu_opcode_o), 64'd0);
        chk("rst_cu_op1", 64'(cu_op1_o), 64'd0);
        chk("rst_cu_op2", 64'(cu_op2_o), 64'd0);
        chk("rst_wb_tag", 64'(wb_tag_o), 64'd0);
        chk("rst_wb_rob", 64'(wb_rob_id_o), 64'd0);
        chk("rst_wb_data", 64'(wb_data_o), 64'd0);
        chk("rst_ready", 64'(disp_ready_o), 64'd1);
        rst = 1'b0;
        tick();

        // simple multiply, one-cycle issue latency
        dispatch(3'b000, 32'd7, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0,
                 6'd3, 5'd1, acc);
        chk("mul_lat0", 64'(cu_valid_o), 64'd0);
        tick();
        chk("mul_lat1", 64'(cu_valid_o), 64'd1);
        drain();

        // divide by zero with rs2 woken by wk1 two cycles later
        ulat = 5;
        dispatch(3'b100, 32'd100, 1'b1, 6'd0, 32'd0, 1'b0, 6'd9,
                 6'd5, 5'd2, acc);
        tick();
        wk1_valid_i = 1'b1;
        wk1_tag_i   = 6'd9;
        wk1_data_i  = 32'd0;
        tick();
        wk1_valid_i = 1'b0;
        chk("div_wk_lat0", 64'(cu_valid_o), 64'd0);
        tick();
        chk("div_wk_lat1", 64'(cu_valid_o), 64'd1);
        drain();

        // double wakeup match on a dispatch-cycle source
        ulat = 2;
        wk0_valid_i = 1'b1;
        wk0_tag_i   = 6'd12;
        wk0_data_i  = 32'd5;
        wk1_valid_i = 1'b1;
        wk1_tag_i   = 6'd12;
        wk1_data_i  = 32'd9;
        dispatch(3'b000, 32'd5, 1'b0, 6'd12, 32'd11, 1'b1, 6'd0,
                 6'd6, 5'd3, acc);
        wk0_valid_i = 1'b0;
        wk1_valid_i = 1'b0;
        drain();

        // fill behind a blocked head, refuse while full, then wrap
        dispatch(3'b000, 32'd3, 1'b0, 6'd20, 32'd5, 1'b1, 6'd0,
                 6'd10, 5'd10, acc);
        for (int i = 1; i < 4; i++) begin
            dispatch(3'b101, $urandom, 1'b1, 6'd0,
                     32'($urandom_range(1, 5000)), 1'b1, 6'd0,
                     6'(10 + i), 5'(10 + i), acc);
        end
        chk("full_ready", 64'(disp_ready_o), 64'd0);
        wk0_valid_i = 1'b1;
        wk0_tag_i   = 6'd20;
        wk0_data_i  = 32'd3;
        tick();
        wk0_valid_i = 1'b0;
        chk("full_no_issue", 64'(cu_valid_o), 64'd0);
        dispatch(3'b000, 32'd77, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0,
                 6'd30, 5'd30, acc);
        chk("full_refuse", {63'd0, acc}, 64'd0);
        chk("pop_ready", 64'(disp_ready_o), 64'd1);
        chk("pop_issue", 64'(cu_valid_o), 64'd1);
        disp_retry(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 6'd14, 5'd14);
        disp_retry(3'b110, 32'hFFFF_FFF9, 32'd2, 6'd15, 5'd15);
        disp_retry(3'b111, $urandom, 32'd0, 6'd16, 5'd16);
        for (int i = 0; i < 3; i++) begin
            disp_retry(3'($urandom_range(4, 7)), $urandom,
                       32'($urandom_range(0, 300)), 6'(17 + i), 5'(17 + i));
        end
        drain();

        // flush with a divide in flight and three ops queued
        ulat = 30;
        dispatch(3'b100, 32'd1000, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0,
                 6'd40, 5'd20, acc);
        for (int i = 0; i < 3; i++) begin
            dispatch(3'b000, 32'(i + 2), 1'b1, 6'd0, 32'd3, 1'b1, 6'd0,
                     6'(41 + i), 5'(21 + i), acc);
        end
        tick();
        flush_i    = 1'b1;
        force_done = 1'b1;
        #1;
        chk("flush_pass", 64'(cu_flush_o), 64'd1);
        dispatch(3'b000, 32'd9, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0,
                 6'd50, 5'd25, acc);
        chk("flush_drop_disp", {63'd0, acc}, 64'd0);
        flush_i    = 1'b0;
        force_done = 1'b0;
        iss_q.delete();
        wb_q.delete();
        chk("flush_cu_valid", 64'(cu_valid_o), 64'd0);
        chk("flush_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("flush_ready", 64'(disp_ready_o), 64'd1);
        repeat (3) tick();
        ulat = 2;
        dispatch(3'b000, 32'd12, 1'b1, 6'd0, 32'd12, 1'b1, 6'd0,
                 6'd51, 5'd26, acc);
        tick();
        chk("post_flush_issue", 64'(cu_valid_o), 64'd1);
        drain();

        // asynchronous reset while an op is being issued
        ulat = 30;
        dispatch(3'b101, 32'd500, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0,
                 6'd52, 5'd27, acc);
        dispatch(3'b000, 32'd4, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0,
                 6'd53, 5'd28, acc);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cu_valid", 64'(cu_valid_o), 64'd0);
        chk("arst_cu_op1", 64'(cu_op1_o), 64'd0);
        chk("arst_cu_op", 64'(cu_opcode_o), 64'd0);
        chk("arst_wb_data", 64'(wb_data_o), 64'd0);
        chk("arst_wb_tag", 64'(wb_tag_o), 64'd0);
        iss_q.delete();
        wb_q.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("arst_rel_ready", 64'(disp_ready_o), 64'd1);
        repeat (3) tick();
        ulat = 2;
        dispatch(3'b000, 32'd8, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0,
                 6'd54, 5'd29, acc);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
